memory_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline: consumes the EX/MEM register contents and produces the MEM/WB register contents consumed by the write-back stage.
- Performs loads and stores over a request/acknowledge data-memory port, including byte-lane steering and load sign/zero extension.
- Stalls the upstream pipeline while an access is outstanding and inserts bubbles into WB.

---
 rtl/memory_stage.sv | 196 +++++++++++++++++++
 tb/tb_memory_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage: load/store over a req/ack data port, MEM/WB register
module memory_stage #(
    parameter int DMEM_MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instruction,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_load_unsigned,
    input  logic        ex_gpr_we,
    input  logic [4:0]  ex_gpr_wreg,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_instruction,
    output logic        wb_gpr_we,
    output logic [4:0]  wb_gpr_wreg,
    output logic [31:0] wb_gpr_wdata,
    output logic        misalign_exc,
    output logic        timeout_err
);

    localparam int CW = 16;

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t      state, state_next;

    // Fields captured when an access is accepted; they drive the memory port until ack.
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic        l_unsigned;
    logic        l_write;
    logic [31:0] l_store_data;
    logic [31:0] l_pc;
    logic [31:0] l_instruction;
    logic        l_gpr_we;
    logic [4:0]  l_gpr_wreg;
    logic [CW-1:0] wait_cnt;

    logic        memop;
    logic        misaligned;
    logic        accept;
    logic [1:0]  lane;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;
    logic [CW-1:0] wait_cnt_next;

    // Decode the incoming EX/MEM entry: memory op, alignment and whether an access starts.
    always_comb begin
        memop      = ex_valid & (ex_mem_read | ex_mem_write);
        misaligned = 1'b0;
        case (ex_mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_alu_result[0];
            default: misaligned = (ex_alu_result[1:0] != 2'b00);
        endcase
        misaligned = misaligned & memop;
        accept     = (state == IDLE) & memop & ~misaligned;
    end

    // Next state and stall: stall while an access is being set up or is awaiting ack.
    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        case (state)
            IDLE: begin
                stall_out = accept;
                if (accept) state_next = ACCESS;
            end
            ACCESS: begin
                stall_out = ~dmem_ack;
                if (dmem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port driven purely from latched fields so it holds steady until ack.
    always_comb begin
        lane       = l_addr[1:0];
        dmem_req   = (state == ACCESS);
        dmem_we    = l_write;
        dmem_addr  = {l_addr[31:2], 2'b00};
        dmem_be    = 4'b1111;
        dmem_wdata = l_store_data;
        case (l_size)
            2'b00: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{l_store_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << lane;
                dmem_wdata = {2{l_store_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = l_store_data;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension of the returned word.
    always_comb begin
        rdata_shifted = dmem_rdata >> {lane, 3'b000};
        case (l_size)
            2'b00:   load_data = l_unsigned ? {24'h0, rdata_shifted[7:0]}
                                            : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_data = l_unsigned ? {16'h0, rdata_shifted[15:0]}
                                            : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
        wait_cnt_next = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
    end

    // State, latched access fields, wait counter and the MEM/WB register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            l_addr         <= '0;
            l_size         <= '0;
            l_unsigned     <= 1'b0;
            l_write        <= 1'b0;
            l_store_data   <= '0;
            l_pc           <= '0;
            l_instruction  <= '0;
            l_gpr_we       <= 1'b0;
            l_gpr_wreg     <= '0;
            wait_cnt       <= '0;
            wb_valid       <= 1'b0;
            wb_pc          <= '0;
            wb_instruction <= '0;
            wb_gpr_we      <= 1'b0;
            wb_gpr_wreg    <= '0;
            wb_gpr_wdata   <= '0;
            misalign_exc   <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state        <= state_next;
            misalign_exc <= 1'b0;
            timeout_err  <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    l_addr        <= ex_alu_result;
                    l_size        <= ex_mem_size;
                    l_unsigned    <= ex_load_unsigned;
                    l_write       <= ex_mem_write;
                    l_store_data  <= ex_store_data;
                    l_pc          <= ex_pc;
                    l_instruction <= ex_instruction;
                    l_gpr_we      <= ex_gpr_we;
                    l_gpr_wreg    <= ex_gpr_wreg;
                    wait_cnt      <= '0;
                    wb_valid      <= 1'b0;
                    wb_gpr_we     <= 1'b0;
                end else begin
                    wb_valid       <= ex_valid;
                    wb_pc          <= ex_pc;
                    wb_instruction <= ex_instruction;
                    wb_gpr_we      <= ex_valid & ex_gpr_we & ~misaligned;
                    wb_gpr_wreg    <= ex_gpr_wreg;
                    wb_gpr_wdata   <= ex_alu_result;
                    misalign_exc   <= misaligned;
                end
            end else begin
                if (dmem_ack) begin
                    wb_valid       <= 1'b1;
                    wb_pc          <= l_pc;
                    wb_instruction <= l_instruction;
                    wb_gpr_we      <= l_gpr_we & ~l_write;
                    wb_gpr_wreg    <= l_gpr_wreg;
                    wb_gpr_wdata   <= l_write ? l_addr : load_data;
                end else begin
                    wb_valid    <= 1'b0;
                    wb_gpr_we   <= 1'b0;
                    wait_cnt    <= wait_cnt_next;
                    timeout_err <= (DMEM_MAX_WAIT > 0) && (wait_cnt_next == CW'(DMEM_MAX_WAIT));
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instruction;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_load_unsigned;
    logic        ex_gpr_we;
    logic [4:0]  ex_gpr_wreg;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_instruction;
    logic        wb_gpr_we;
    logic [4:0]  wb_gpr_wreg;
    logic [31:0] wb_gpr_wdata;
    logic        misalign_exc;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    memory_stage #(.DMEM_MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instruction(ex_instruction),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
        .ex_load_unsigned(ex_load_unsigned), .ex_gpr_we(ex_gpr_we), .ex_gpr_wreg(ex_gpr_wreg),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instruction(wb_instruction),
        .wb_gpr_we(wb_gpr_we), .wb_gpr_wreg(wb_gpr_wreg), .wb_gpr_wdata(wb_gpr_wdata),
        .misalign_exc(misalign_exc), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] sd);
        ex_valid         = 1'b1;
        ex_mem_read      = ~wr;
        ex_mem_write     = wr;
        ex_mem_size      = sz;
        ex_load_unsigned = uns;
        ex_alu_result    = addr;
        ex_store_data    = sd;
        ex_gpr_we        = 1'b1;
        ex_gpr_wreg      = 5'd9;
        ex_pc            = 32'h0000_0400;
        ex_instruction   = 32'h8C09_0000;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic mem_op(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rd, input int waits);
        drive_mem(wr, sz, uns, addr, sd);
        #1;
        chk({tag, "_stall_setup"}, {31'b0, stall_out}, 32'd1);
        tick();
        chk({tag, "_bubble0"}, {31'b0, wb_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_req_wait"}, {31'b0, dmem_req}, 32'd1);
            chk({tag, "_stall_wait"}, {31'b0, stall_out}, 32'd1);
            chk({tag, "_addr_wait"}, dmem_addr, {addr[31:2], 2'b00});
            tick();
            chk({tag, "_bubble"}, {31'b0, wb_valid}, 32'd0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
        #1;
        cap_addr  = dmem_addr;
        cap_wdata = dmem_wdata;
        cap_be    = dmem_be;
        cap_we    = dmem_we;
        chk({tag, "_stall_ack"}, {31'b0, stall_out}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        idle_ex();
        chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; ex_pc = '0; ex_instruction = '0; ex_alu_result = '0;
        ex_store_data = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = 2'b10;
        ex_load_unsigned = 1'b0; ex_gpr_we = 1'b0; ex_gpr_wreg = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_exc}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
        chk("rst_wdata", wb_gpr_wdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // ALU-type pass-through
        ex_valid = 1'b1; ex_alu_result = 32'h0000_1234; ex_gpr_we = 1'b1; ex_gpr_wreg = 5'd8;
        ex_pc = 32'h0000_0100; ex_instruction = 32'h0123_4020;
        #1;
        chk("alu_stall", {31'b0, stall_out}, 32'd0);
        chk("alu_req", {31'b0, dmem_req}, 32'd0);
        tick();
        idle_ex();
        chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("alu_wdata", wb_gpr_wdata, 32'h0000_1234);
        chk("alu_wreg", {27'b0, wb_gpr_wreg}, 32'd8);
        chk("alu_we", {31'b0, wb_gpr_we}, 32'd1);
        chk("alu_pc", wb_pc, 32'h0000_0100);

        // lw with three wait cycles
        mem_op("lw", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
        chk("lw_data", wb_gpr_wdata, 32'hDEAD_BEEF);
        chk("lw_we", {31'b0, wb_gpr_we}, 32'd1);
        chk("lw_addr", cap_addr, 32'h0000_0100);
        chk("lw_be", {28'b0, cap_be}, 32'hF);
        chk("lw_dmem_we", {31'b0, cap_we}, 32'd0);
        chk("lw_timeout", {31'b0, timeout_err}, 32'd0);

        // byte loads, signed and unsigned
        mem_op("lb", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        chk("lb_data", wb_gpr_wdata, 32'hFFFF_FF80);
        mem_op("lbu", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        chk("lbu_data", wb_gpr_wdata, 32'h0000_0080);

        // signed halfword from upper lane
        mem_op("lh", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_1234, 1);
        chk("lh_data", wb_gpr_wdata, 32'hFFFF_8001);

        // halfword store
        mem_op("sh", 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
        chk("sh_be", {28'b0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_addr", cap_addr, 32'h0000_0200);
        chk("sh_dmem_we", {31'b0, cap_we}, 32'd1);
        chk("sh_gpr_we", {31'b0, wb_gpr_we}, 32'd0);

        // byte store
        mem_op("sb", 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5678, 32'h0, 0);
        chk("sb_be", {28'b0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'h7878_7878);

        // misaligned word load
        drive_mem(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        #1;
        chk("mis_stall", {31'b0, stall_out}, 32'd0);
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        tick();
        idle_ex();
        chk("mis_exc", {31'b0, misalign_exc}, 32'd1);
        chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("mis_gpr_we", {31'b0, wb_gpr_we}, 32'd0);
        chk("mis_req_after", {31'b0, dmem_req}, 32'd0);
        tick();
        chk("mis_exc_pulse", {31'b0, misalign_exc}, 32'd0);

        // timeout after four unacknowledged access cycles
        drive_mem(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("to_pulse", {31'b0, timeout_err}, (k == 4) ? 32'd1 : 32'd0);
            chk("to_req", {31'b0, dmem_req}, 32'd1);
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        tick();
        dmem_ack = 1'b0;
        idle_ex();
        chk("to_done_valid", {31'b0, wb_valid}, 32'd1);
        chk("to_done_data", wb_gpr_wdata, 32'h0BAD_F00D);

        // reset on the second access cycle, late ack ignored
        drive_mem(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        tick();
        chk("rma_req_before", {31'b0, dmem_req}, 32'd1);
        reset = 1'b1;
        idle_ex();
        #1;
        chk("rma_req", {31'b0, dmem_req}, 32'd0);
        chk("rma_stall", {31'b0, stall_out}, 32'd0);
        chk("rma_wb_valid", {31'b0, wb_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #1;
        chk("rma_ack_req", {31'b0, dmem_req}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("rma_late_valid", {31'b0, wb_valid}, 32'd0);
        chk("rma_late_req", {31'b0, dmem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
